// File: rtl/fram_bus_responder_if.sv
// CPU system bus bundle between a bus initiator (master) and a memory responder (slave).
// WPROT/ACCV_CLR exist only when FRAM_WPROT_EN is defined.
interface fram_bus_responder_if;
  logic [15:0] MAB;
  logic [15:0] MDBin;
  logic [15:0] MDBout;
  logic        MW;
  logic        BW;
  logic        SEL;
  logic        HOLD;
  logic        ACCV;
`ifdef FRAM_WPROT_EN
  logic        WPROT;
  logic        ACCV_CLR;

  modport master (
    output MAB, MDBin, MW, BW, WPROT, ACCV_CLR,
    input  MDBout, SEL, HOLD, ACCV
  );

  modport slave (
    input  MAB, MDBin, MW, BW, WPROT, ACCV_CLR,
    output MDBout, SEL, HOLD, ACCV
  );
`else
  modport master (
    output MAB, MDBin, MW, BW,
    input  MDBout, SEL, HOLD, ACCV
  );

  modport slave (
    input  MAB, MDBin, MW, BW,
    output MDBout, SEL, HOLD, ACCV
  );
`endif
endinterface

// File: rtl/fram_bus_responder.sv
// FRAM window responder: decodes MAB, services word/byte accesses, stalls via HOLD for NWAITS.
// Optional write protection with sticky ACCV is enabled by defining FRAM_WPROT_EN.
module fram_bus_responder #(
  parameter logic [15:0] BASE       = 16'h4400,
  parameter int unsigned SIZE_WORDS = 1024,
  parameter int unsigned NWAITS     = 1
) (
  input  logic                 MCLK,
  input  logic                 RSTn,
  fram_bus_responder_if.slave  bus
);

  localparam int unsigned Aw       = (SIZE_WORDS > 1) ? $clog2(SIZE_WORDS) : 1;
  localparam logic [16:0] WinEnd   = 17'(BASE) + 17'(2 * SIZE_WORDS) - 17'd1;
  localparam bit          HasWaits = (NWAITS != 0);
  localparam logic [2:0]  WaitLoad = HasWaits ? 3'(NWAITS - 1) : 3'd0;

  typedef enum logic {StIdle, StWait} state_e;

  state_e          state_q;
  logic [2:0]      wcnt_q;
  logic            sel;
  logic            hold;
  logic            complete;
  logic            mem_we;
  logic [Aw-1:0]   word_idx;
  logic [15:0]     word_rd;
  logic [15:0]     rdata;
  logic [15:0]     wdata;

  // Non-volatile model: contents start at zero and are never touched by reset.
  logic [15:0] mem_q [SIZE_WORDS] = '{default: 16'h0000};

  assign sel      = ({1'b0, bus.MAB} >= {1'b0, BASE}) && ({1'b0, bus.MAB} <= WinEnd);
  assign word_idx = Aw'((bus.MAB - BASE) >> 1);
  assign word_rd  = mem_q[word_idx];

  always_comb begin
    hold = 1'b0;
    if (RSTn && sel) begin
      unique case (state_q)
        StIdle:  hold = HasWaits;
        StWait:  hold = (wcnt_q != 3'd0);
        default: hold = 1'b0;
      endcase
    end
  end

  assign complete = RSTn & sel & ~hold;

  always_comb begin
    rdata = word_rd;
    wdata = bus.MDBin;
    if (bus.BW) begin
      rdata = bus.MAB[0] ? {8'h00, word_rd[15:8]} : {8'h00, word_rd[7:0]};
      wdata = bus.MAB[0] ? {bus.MDBin[7:0], word_rd[7:0]} : {word_rd[15:8], bus.MDBin[7:0]};
    end
  end

`ifdef FRAM_WPROT_EN
  logic viol;
  logic accv_q;

  assign viol   = complete & bus.MW & bus.WPROT;
  assign mem_we = complete & bus.MW & ~bus.WPROT;

  // A violation on the same edge as a clear keeps the flag set.
  always_ff @(posedge MCLK or negedge RSTn) begin
    if (!RSTn) begin
      accv_q <= 1'b0;
    end else if (viol) begin
      accv_q <= 1'b1;
    end else if (bus.ACCV_CLR) begin
      accv_q <= 1'b0;
    end
  end

  assign bus.ACCV = accv_q;
`else
  assign mem_we   = complete & bus.MW;
  assign bus.ACCV = 1'b0;
`endif

  always_ff @(posedge MCLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= StIdle;
      wcnt_q  <= 3'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (sel && HasWaits) begin
            state_q <= StWait;
            wcnt_q  <= WaitLoad;
          end
        end
        StWait: begin
          if (!sel) begin
            state_q <= StIdle;
            wcnt_q  <= 3'd0;
          end else if (wcnt_q != 3'd0) begin
            wcnt_q  <= wcnt_q - 3'd1;
          end else begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
          wcnt_q  <= 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge MCLK) begin
    if (mem_we) begin
      mem_q[word_idx] <= wdata;
    end
  end

  assign bus.SEL    = sel;
  assign bus.HOLD   = hold;
  assign bus.MDBout = (complete && !bus.MW) ? rdata : 16'h0000;

endmodule

// File: tb/tb_fram_bus_responder.sv
// Directed bench for fram_bus_responder: one instance with NWAITS=1, one with NWAITS=3.
module tb_fram_bus_responder;

  logic clk = 1'b0;
  logic rst_n1;
  logic rst_n3;
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  fram_bus_responder_if b1 ();
  fram_bus_responder_if b3 ();

  fram_bus_responder #(
    .BASE       (16'h4400),
    .SIZE_WORDS (1024),
    .NWAITS     (1)
  ) u_dut1 (
    .MCLK (clk),
    .RSTn (rst_n1),
    .bus  (b1.slave)
  );

  fram_bus_responder #(
    .BASE       (16'h4400),
    .SIZE_WORDS (1024),
    .NWAITS     (3)
  ) u_dut3 (
    .MCLK (clk),
    .RSTn (rst_n3),
    .bus  (b3.slave)
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit w3, input logic [15:0] addr, input logic mw, input logic bw,
                       input logic [15:0] din);
    if (w3) begin
      b3.MAB = addr; b3.MW = mw; b3.BW = bw; b3.MDBin = din;
    end else begin
      b1.MAB = addr; b1.MW = mw; b1.BW = bw; b1.MDBin = din;
    end
  endtask

  // Runs one access from posedge+1; returns completion-cycle MDBout, HOLD cycles, and whether
  // MDBout was nonzero while HOLD was high.
  task automatic bus_access(input bit w3, input logic [15:0] addr, input logic mw,
                            input logic bw, input logic [15:0] din, output logic [15:0] rd,
                            output int nhold, output logic early_nz);
    logic done;
    logic h;
    logic [15:0] m;
    done     = 1'b0;
    nhold    = 0;
    early_nz = 1'b0;
    rd       = 16'hxxxx;
    drive(w3, addr, mw, bw, din);
    for (int c = 0; c < 12 && !done; c++) begin
      @(negedge clk);
      h = w3 ? b3.HOLD : b1.HOLD;
      m = w3 ? b3.MDBout : b1.MDBout;
      if (h) begin
        nhold++;
        if (m != 16'h0000) early_nz = 1'b1;
      end else begin
        rd   = m;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    check_eq("access_done", {15'd0, done}, 16'd1);
    drive(w3, 16'h0000, 1'b0, 1'b0, 16'h0000);
  endtask

  logic [15:0] rd;
  int          nh;
  logic        enz;

  initial begin
    rst_n1 = 1'b0;
    rst_n3 = 1'b0;
    drive(1'b0, 16'h4400, 1'b0, 1'b0, 16'h0000);
    drive(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000);
`ifdef FRAM_WPROT_EN
    b1.WPROT = 1'b0; b1.ACCV_CLR = 1'b0;
    b3.WPROT = 1'b0; b3.ACCV_CLR = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_hold",   {15'd0, b1.HOLD}, 16'd0);
    check_eq("rst_mdbout", b1.MDBout, 16'h0000);
    check_eq("rst_accv",   {15'd0, b1.ACCV}, 16'd0);
    @(posedge clk);
    #1;
    rst_n1 = 1'b1;
    rst_n3 = 1'b1;
    @(negedge clk);
    check_eq("post_rst_hold_c1", {15'd0, b1.HOLD}, 16'd1);
    check_eq("post_rst_mdb_c1",  b1.MDBout, 16'h0000);
    @(negedge clk);
    check_eq("post_rst_hold_c2", {15'd0, b1.HOLD}, 16'd0);
    check_eq("post_rst_mdb_c2",  b1.MDBout, 16'h0000);
    @(posedge clk);
    #1;
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    @(posedge clk);
    #1;

    // Word write/read, NWAITS=1
    bus_access(1'b0, 16'h4402, 1'b1, 1'b0, 16'h1234, rd, nh, enz);
    check_eq("wr_hold_cycles", 16'(nh), 16'd1);
    bus_access(1'b0, 16'h4402, 1'b0, 1'b0, 16'h0000, rd, nh, enz);
    check_eq("rd_word",        rd, 16'h1234);
    check_eq("rd_hold_cycles", 16'(nh), 16'd1);
    check_eq("rd_early_zero",  {15'd0, enz}, 16'd0);

    // Byte lanes
    bus_access(1'b0, 16'h4403, 1'b1, 1'b1, 16'h77AB, rd, nh, enz);
    bus_access(1'b0, 16'h4402, 1'b0, 1'b0, 16'h0000, rd, nh, enz);
    check_eq("rd_after_hi_byte", rd, 16'hAB34);
    bus_access(1'b0, 16'h4403, 1'b0, 1'b0, 16'h0000, rd, nh, enz);
    check_eq("rd_word_odd_addr", rd, 16'hAB34);
    bus_access(1'b0, 16'h4402, 1'b0, 1'b1, 16'h0000, rd, nh, enz);
    check_eq("rd_byte_lo", rd, 16'h0034);
    bus_access(1'b0, 16'h4403, 1'b0, 1'b1, 16'h0000, rd, nh, enz);
    check_eq("rd_byte_hi", rd, 16'h00AB);
    bus_access(1'b0, 16'h4402, 1'b1, 1'b1, 16'h99CD, rd, nh, enz);
    bus_access(1'b0, 16'h4402, 1'b0, 1'b0, 16'h0000, rd, nh, enz);
    check_eq("rd_after_lo_byte", rd, 16'hABCD);

    // Window edges
    drive(1'b0, 16'h4BFE, 1'b0, 1'b0, 16'h0000);
    #1;
    check_eq("sel_4bfe", {15'd0, b1.SEL}, 16'd1);
    @(posedge clk);
    #1;
    drive(1'b0, 16'h4BFF, 1'b0, 1'b0, 16'h0000);
    #1;
    check_eq("sel_4bff", {15'd0, b1.SEL}, 16'd1);
    @(posedge clk);
    #1;
    drive(1'b0, 16'h43FF, 1'b0, 1'b0, 16'h0000);
    #1;
    check_eq("sel_43ff",  {15'd0, b1.SEL}, 16'd0);
    check_eq("hold_43ff", {15'd0, b1.HOLD}, 16'd0);
    check_eq("mdb_43ff",  b1.MDBout, 16'h0000);
    drive(1'b0, 16'h4C00, 1'b0, 1'b0, 16'h0000);
    #1;
    check_eq("sel_4c00",  {15'd0, b1.SEL}, 16'd0);
    check_eq("hold_4c00", {15'd0, b1.HOLD}, 16'd0);
    check_eq("mdb_4c00",  b1.MDBout, 16'h0000);
    @(posedge clk);
    #1;
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    @(posedge clk);
    #1;

    // NWAITS=3: abort after one cycle, then full accesses
    drive(1'b1, 16'h4410, 1'b1, 1'b0, 16'hBEEF);
    @(negedge clk);
    check_eq("abort_hold_c1", {15'd0, b3.HOLD}, 16'd1);
    @(posedge clk);
    #1;
    drive(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000);
    @(posedge clk);
    #1;
    bus_access(1'b1, 16'h4410, 1'b0, 1'b0, 16'h0000, rd, nh, enz);
    check_eq("abort_no_write",  rd, 16'h0000);
    check_eq("w3_rd_hold",      16'(nh), 16'd3);
    bus_access(1'b1, 16'h4410, 1'b1, 1'b0, 16'hCAFE, rd, nh, enz);
    check_eq("w3_wr_hold",      16'(nh), 16'd3);
    bus_access(1'b1, 16'h4410, 1'b0, 1'b0, 16'h0000, rd, nh, enz);
    check_eq("w3_rd_data",      rd, 16'hCAFE);
    check_eq("w3_rd_early_zero", {15'd0, enz}, 16'd0);

    // Reset pulse during WAIT
    drive(1'b1, 16'h4410, 1'b1, 1'b0, 16'hDEAD);
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("rstw_hold_before", {15'd0, b3.HOLD}, 16'd1);
    #1;
    rst_n3 = 1'b0;
    #1;
    check_eq("rstw_hold_drop", {15'd0, b3.HOLD}, 16'd0);
    @(posedge clk);
    #1;
    drive(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000);
    @(posedge clk);
    #1;
    rst_n3 = 1'b1;
    @(posedge clk);
    #1;
    bus_access(1'b1, 16'h4410, 1'b0, 1'b0, 16'h0000, rd, nh, enz);
    check_eq("rstw_no_write", rd, 16'hCAFE);
    check_eq("rstw_rd_hold",  16'(nh), 16'd3);

`ifdef FRAM_WPROT_EN
    b1.WPROT = 1'b1;
    bus_access(1'b0, 16'h4400, 1'b1, 1'b0, 16'h5555, rd, nh, enz);
    check_eq("wp_accv_set", {15'd0, b1.ACCV}, 16'd1);
    b1.WPROT = 1'b0;
    bus_access(1'b0, 16'h4400, 1'b0, 1'b0, 16'h0000, rd, nh, enz);
    check_eq("wp_array_kept", rd, 16'h0000);
    b1.WPROT    = 1'b1;
    b1.ACCV_CLR = 1'b1;
    bus_access(1'b0, 16'h4400, 1'b1, 1'b0, 16'h5555, rd, nh, enz);
    b1.WPROT    = 1'b0;
    b1.ACCV_CLR = 1'b0;
    check_eq("wp_viol_beats_clr", {15'd0, b1.ACCV}, 16'd1);
    b1.ACCV_CLR = 1'b1;
    @(posedge clk);
    #1;
    b1.ACCV_CLR = 1'b0;
    check_eq("wp_clr_alone", {15'd0, b1.ACCV}, 16'd0);
`else
    bus_access(1'b0, 16'h4400, 1'b1, 1'b0, 16'h5555, rd, nh, enz);
    check_eq("accv_tied_zero", {15'd0, b1.ACCV}, 16'd0);
    bus_access(1'b0, 16'h4400, 1'b0, 1'b0, 16'h0000, rd, nh, enz);
    check_eq("wr_4400_commits", rd, 16'h5555);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
